// File: rtl/mini_core_pkg.sv
// mini_core_pkg: shared types and memory-map bounds for the mini core fabric.
//   t_arb_state - memory arbiter FSM states
//   t_mem_sel   - one-hot region select driven onto MemSel
//   *_FLOOR/*_ROOF - inclusive region bounds
//   decode()    - byte address -> region select (SEL_NONE if unmapped)
package mini_core_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    ERR_RSP = 2'd2
  } t_arb_state;

  typedef enum logic [3:0] {
    SEL_NONE = 4'b0000,
    SEL_I    = 4'b0001,
    SEL_D    = 4'b0010,
    SEL_CR   = 4'b0100,
    SEL_VGA  = 4'b1000
  } t_mem_sel;

  localparam logic [31:0] I_MEM_FLOOR   = 32'h0000_0000;
  localparam logic [31:0] I_MEM_ROOF    = 32'h0000_3FFF;
  localparam logic [31:0] D_MEM_FLOOR   = 32'h0000_4000;
  localparam logic [31:0] D_MEM_ROOF    = 32'h0000_6FFF;
  localparam logic [31:0] CR_MEM_FLOOR  = 32'h0000_7000;
  localparam logic [31:0] CR_MEM_ROOF   = 32'h0000_7FFF;
  localparam logic [31:0] VGA_MEM_FLOOR = 32'h0000_8000;
  localparam logic [31:0] VGA_MEM_ROOF  = 32'h0001_15FF;

  localparam int NUM_REQ = 2;

  function automatic logic in_rgn(input logic [31:0] a, input logic [31:0] f,
                                  input logic [31:0] r);
    return (a >= f) && (a <= r);
  endfunction

  function automatic t_mem_sel decode(input logic [31:0] a);
    if (in_rgn(a, I_MEM_FLOOR, I_MEM_ROOF))     return SEL_I;
    if (in_rgn(a, D_MEM_FLOOR, D_MEM_ROOF))     return SEL_D;
    if (in_rgn(a, CR_MEM_FLOOR, CR_MEM_ROOF))   return SEL_CR;
    if (in_rgn(a, VGA_MEM_FLOOR, VGA_MEM_ROOF)) return SEL_VGA;
    return SEL_NONE;
  endfunction

endpackage

// File: rtl/mini_core_rr_arb.sv
// mini_core_rr_arb: 2-way grant generator for the memory arbiter.
//   req - request vector, gnt - one-hot grant (zero if no request)
//   With MINI_CORE_MEM_ARB_RR_EN: round-robin; Clk/RstN/upd exist and
//   upd advances the pointer on every accepted grant. Otherwise fixed
//   priority (requester 0 wins) and the block is purely combinational.
module mini_core_rr_arb (
`ifdef MINI_CORE_MEM_ARB_RR_EN
  input  logic       Clk,
  input  logic       RstN,
  input  logic       upd,
`endif
  input  logic [1:0] req,
  output logic [1:0] gnt
);

`ifdef MINI_CORE_MEM_ARB_RR_EN
  // last = requester granted most recently; reset to 1 so requester 0
  // wins the first contention.
  logic last;

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN)    last <= 1'b1;
    else if (upd) last <= gnt[1];
  end

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last ? 2'b01 : 2'b10;
  end
`else
  always_comb begin
    gnt = 2'b00;
    if (req[0])      gnt = 2'b01;
    else if (req[1]) gnt = 2'b10;
  end
`endif

endmodule

// File: rtl/mini_core_mem_arb.sv
// mini_core_mem_arb: two-requester memory arbiter with region decode.
//   Req*  - requester side (bit/lane 0 = core data, 1 = loader/debug)
//   Rsp*  - registered one-cycle read/error response per requester
//   Mem*  - fabric request, MemSel one-hot region, MemRdData read return
// One transaction outstanding. Grants are combinational in IDLE; reads
// return RD_LATENCY+1 cycles after grant; unmapped addresses get an
// error response the following cycle.
// Macro MINI_CORE_MEM_ARB_RR_EN selects round-robin instead of fixed
// priority in the grant sub-module.
module mini_core_mem_arb
  import mini_core_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic             Clk,
  input  logic             RstN,
  input  logic [1:0]       ReqValid,
  output logic [1:0]       ReqReady,
  input  logic [1:0][31:0] ReqAddr,
  input  logic [1:0]       ReqWr,
  input  logic [1:0][3:0]  ReqByteEn,
  input  logic [1:0][31:0] ReqWrData,
  output logic [1:0]       RspValid,
  output logic [31:0]      RspData,
  output logic [1:0]       RspErr,
  output logic             MemReqValid,
  output logic [31:0]      MemAddr,
  output logic             MemWr,
  output logic [3:0]       MemByteEn,
  output logic [31:0]      MemWrData,
  output logic [3:0]       MemSel,
  input  logic [31:0]      MemRdData
);

  localparam logic [2:0] LAT = 3'(RD_LATENCY);

  t_arb_state state, state_nxt;
  t_mem_sel   sel;
  logic [2:0] cnt;
  logic [1:0] gnt, gnt_q;
  logic       gidx, active, any, legal;

  // Reset gates the combinational outputs too, so they read 0 while
  // RstN is low regardless of requests.
  assign active = RstN && (state == IDLE);
  assign any    = |ReqValid;
  assign gidx   = gnt[1];
  assign sel    = decode(ReqAddr[gidx]);
  assign legal  = (sel != SEL_NONE);

  mini_core_rr_arb u_arb (
`ifdef MINI_CORE_MEM_ARB_RR_EN
    .Clk  (Clk),
    .RstN (RstN),
    .upd  (active && any),
`endif
    .req  (ReqValid),
    .gnt  (gnt)
  );

  always_comb begin
    state_nxt   = state;
    ReqReady    = 2'b00;
    MemReqValid = 1'b0;
    MemSel      = SEL_NONE;
    MemAddr     = '0;
    MemWr       = 1'b0;
    MemByteEn   = '0;
    MemWrData   = '0;
    case (state)
      IDLE: begin
        if (active && any) begin
          ReqReady = gnt;
          if (legal) begin
            MemReqValid = 1'b1;
            MemSel      = sel;
            MemAddr     = ReqAddr[gidx];
            MemWr       = ReqWr[gidx];
            MemByteEn   = ReqByteEn[gidx];
            MemWrData   = ReqWrData[gidx];
            if (!ReqWr[gidx]) state_nxt = RD_WAIT;
          end else begin
            state_nxt = ERR_RSP;
          end
        end
      end
      RD_WAIT: if (cnt == LAT) state_nxt = IDLE;
      ERR_RSP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) state <= IDLE;
    else       state <= state_nxt;
  end

  // cnt = cycles spent in RD_WAIT; MemRdData is valid on the cycle cnt
  // reaches RD_LATENCY and is registered into the response.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      cnt      <= '0;
      gnt_q    <= '0;
      RspValid <= '0;
      RspErr   <= '0;
      RspData  <= '0;
    end else begin
      RspValid <= '0;
      RspErr   <= '0;
      if (state == IDLE && any) begin
        gnt_q <= gnt;
        cnt   <= 3'd1;
        if (!legal) begin
          RspValid <= gnt;
          RspErr   <= gnt;
          RspData  <= '0;
        end
      end else if (state == RD_WAIT) begin
        if (cnt == LAT) begin
          RspValid <= gnt_q;
          RspData  <= MemRdData;
          cnt      <= '0;
        end else begin
          cnt <= cnt + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mini_core_mem_arb.sv
// Bench for mini_core_mem_arb: one instance at RD_LATENCY=1 (vector table,
// back-to-back writes, contention) and one at RD_LATENCY=4 (reset during
// RD_WAIT, long-latency read). Inputs change on the falling edge, outputs
// are sampled 1 time unit later.
module tb_mini_core_mem_arb;

  logic Clk = 1'b0;
  logic RstN = 1'b0;
  always #5 Clk = ~Clk;

  logic [1:0]       ReqValid, ReqValid4;
  logic [1:0][31:0] ReqAddr;
  logic [1:0]       ReqWr;
  logic [1:0][3:0]  ReqByteEn;
  logic [1:0][31:0] ReqWrData;
  logic [31:0]      MemRdData;

  logic [1:0]  rdy, rsp_vld, rsp_err;
  logic [31:0] rsp_data, maddr, mwd;
  logic        mvld, mwr;
  logic [3:0]  mbe, msel;

  logic [1:0]  rdy4, rsp_vld4, rsp_err4;
  logic [31:0] rsp_data4, maddr4, mwd4;
  logic        mvld4, mwr4;
  logic [3:0]  mbe4, msel4;

  mini_core_mem_arb #(.RD_LATENCY(1)) dut (
    .Clk(Clk), .RstN(RstN), .ReqValid(ReqValid), .ReqReady(rdy),
    .ReqAddr(ReqAddr), .ReqWr(ReqWr), .ReqByteEn(ReqByteEn), .ReqWrData(ReqWrData),
    .RspValid(rsp_vld), .RspData(rsp_data), .RspErr(rsp_err),
    .MemReqValid(mvld), .MemAddr(maddr), .MemWr(mwr), .MemByteEn(mbe),
    .MemWrData(mwd), .MemSel(msel), .MemRdData(MemRdData)
  );

  mini_core_mem_arb #(.RD_LATENCY(4)) dut4 (
    .Clk(Clk), .RstN(RstN), .ReqValid(ReqValid4), .ReqReady(rdy4),
    .ReqAddr(ReqAddr), .ReqWr(ReqWr), .ReqByteEn(ReqByteEn), .ReqWrData(ReqWrData),
    .RspValid(rsp_vld4), .RspData(rsp_data4), .RspErr(rsp_err4),
    .MemReqValid(mvld4), .MemAddr(maddr4), .MemWr(mwr4), .MemByteEn(mbe4),
    .MemWrData(mwd4), .MemSel(msel4), .MemRdData(MemRdData)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        r;
    logic [31:0] addr;
    logic        wr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [3:0]  sel;
  } vec_t;

  vec_t tv[12];

  initial begin
    vec_t v;
    logic [1:0] eg, eg_prev;
    logic err, rrmode;

`ifdef MINI_CORE_MEM_ARB_RR_EN
    rrmode = 1'b1;
`else
    rrmode = 1'b0;
`endif

    tv[0]  = '{1'b0, 32'h0000_4000, 1'b1, 4'hF, 32'hDEAD_BEEF, 32'h0,         4'b0010};
    tv[1]  = '{1'b1, 32'h0000_7004, 1'b0, 4'h0, 32'h0,         32'h0000_003F, 4'b0100};
    tv[2]  = '{1'b0, 32'h0000_3FFF, 1'b0, 4'h0, 32'h0,         32'h1111_1111, 4'b0001};
    tv[3]  = '{1'b0, 32'h0000_4000, 1'b0, 4'h0, 32'h0,         32'h2222_2222, 4'b0010};
    tv[4]  = '{1'b1, 32'h0000_6FFF, 1'b1, 4'h3, 32'hA5A5_0001, 32'h0,         4'b0010};
    tv[5]  = '{1'b0, 32'h0000_7000, 1'b0, 4'h0, 32'h0,         32'h3333_3333, 4'b0100};
    tv[6]  = '{1'b1, 32'h0000_7FFF, 1'b0, 4'h0, 32'h0,         32'h4444_4444, 4'b0100};
    tv[7]  = '{1'b0, 32'h0000_8000, 1'b1, 4'hC, 32'h1234_5678, 32'h0,         4'b1000};
    tv[8]  = '{1'b0, 32'h0001_15FF, 1'b0, 4'h0, 32'h0,         32'h5555_5555, 4'b1000};
    tv[9]  = '{1'b0, 32'h0001_1600, 1'b0, 4'h0, 32'h0,         32'h6666_6666, 4'b0000};
    tv[10] = '{1'b1, 32'h0001_1600, 1'b1, 4'hF, 32'hCAFE_0000, 32'h0,         4'b0000};
    tv[11] = '{1'b0, 32'h0000_0000, 1'b1, 4'h3, 32'h0000_BEEF, 32'h0,         4'b0001};

    // Reset held with both requesters active: everything must read 0.
    ReqValid  = 2'b11;
    ReqValid4 = 2'b11;
    ReqAddr   = '{32'h0000_4000, 32'h0000_4000};
    ReqWr     = 2'b00;
    ReqByteEn = '0;
    ReqWrData = '0;
    MemRdData = '0;
    @(negedge Clk); #1;
    chk("rst_ready",   32'(rdy),      32'h0);
    chk("rst_memvld",  32'(mvld),     32'h0);
    chk("rst_memsel",  32'(msel),     32'h0);
    chk("rst_rspvld",  32'(rsp_vld),  32'h0);
    chk("rst_rsperr",  32'(rsp_err),  32'h0);
    chk("rst_rspdata", rsp_data,      32'h0);
    chk("rst_ready4",  32'(rdy4),     32'h0);
    @(negedge Clk);
    RstN = 1'b1; ReqValid = 2'b00; ReqValid4 = 2'b00;

    // Single-request vectors: grant cycle, +1, +2.
    for (int i = 0; i < 12; i++) begin
      v = tv[i];
      @(negedge Clk);
      ReqValid          = 2'b01 << v.r;
      ReqAddr[v.r]      = v.addr;
      ReqWr[v.r]        = v.wr;
      ReqByteEn[v.r]    = v.be;
      ReqWrData[v.r]    = v.wd;
      MemRdData         = v.rd;
      #1;
      eg  = 2'b01 << v.r;
      err = (v.sel == 4'b0000);
      chk($sformatf("v%0d_ready", i),  32'(rdy),  32'(eg));
      chk($sformatf("v%0d_memvld", i), 32'(mvld), 32'(!err));
      chk($sformatf("v%0d_memsel", i), 32'(msel), 32'(v.sel));
      if (!err) begin
        chk($sformatf("v%0d_memaddr", i), maddr,      v.addr);
        chk($sformatf("v%0d_memwr", i),   32'(mwr),   32'(v.wr));
        if (v.wr) begin
          chk($sformatf("v%0d_membe", i), 32'(mbe), 32'(v.be));
          chk($sformatf("v%0d_memwd", i), mwd,      v.wd);
        end
      end
      @(negedge Clk);
      ReqValid = 2'b00;
      #1;
      chk($sformatf("v%0d_c1_rspvld", i), 32'(rsp_vld), err ? 32'(eg) : 32'h0);
      chk($sformatf("v%0d_c1_rsperr", i), 32'(rsp_err), err ? 32'(eg) : 32'h0);
      if (err) chk($sformatf("v%0d_c1_rspdata", i), rsp_data, 32'h0);
      @(negedge Clk); #1;
      chk($sformatf("v%0d_c2_rspvld", i), 32'(rsp_vld), (!err && !v.wr) ? 32'(eg) : 32'h0);
      chk($sformatf("v%0d_c2_rsperr", i), 32'(rsp_err), 32'h0);
      if (!err && !v.wr) chk($sformatf("v%0d_c2_rspdata", i), rsp_data, v.rd);
    end

    // Back-to-back writes from requester 0, one per cycle.
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      ReqValid   = 2'b01;
      ReqAddr[0] = 32'h0000_4100 + 32'(k * 4);
      ReqWr[0]   = 1'b1;
      ReqByteEn[0] = 4'hF;
      ReqWrData[0] = 32'hB0B0_0000 + 32'(k);
      #1;
      chk($sformatf("b2b%0d_ready", k),   32'(rdy),  32'h1);
      chk($sformatf("b2b%0d_memvld", k),  32'(mvld), 32'h1);
      chk($sformatf("b2b%0d_memaddr", k), maddr,     32'h0000_4100 + 32'(k * 4));
      chk($sformatf("b2b%0d_memwd", k),   mwd,       32'hB0B0_0000 + 32'(k));
    end
    @(negedge Clk);
    ReqValid = 2'b00;
    #1;
    chk("b2b_no_rsp", 32'(rsp_vld), 32'h0);

    // Contention: fresh reset, both requesters hold continuous reads.
    @(negedge Clk); RstN = 1'b0;
    @(negedge Clk); RstN = 1'b1;
    @(negedge Clk);
    ReqAddr[0] = 32'h0000_4000; ReqWr[0] = 1'b0;
    ReqAddr[1] = 32'h0000_4004; ReqWr[1] = 1'b0;
    MemRdData  = 32'h0000_0055;
    ReqValid   = 2'b11;
    eg_prev    = 2'b00;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge Clk);
      #1;
      if (c % 2 == 0) begin
        eg = (rrmode && ((c / 2) % 2 == 1)) ? 2'b10 : 2'b01;
        chk($sformatf("cont%0d_grant", c), 32'(rdy), 32'(eg));
        if (c > 0) chk($sformatf("cont%0d_rspvld", c), 32'(rsp_vld), 32'(eg_prev));
        eg_prev = eg;
      end else begin
        chk($sformatf("cont%0d_wait", c), 32'(rdy), 32'h0);
      end
    end
    @(negedge Clk);
    ReqValid = 2'b00;
    @(negedge Clk);
    @(negedge Clk);

    // RD_LATENCY=4: reset in the middle of RD_WAIT aborts the read.
    @(negedge Clk);
    ReqValid4 = 2'b01;
    ReqAddr[0] = 32'h0000_4000; ReqWr[0] = 1'b0;
    #1;
    chk("l4_grant",  32'(rdy4),  32'h1);
    chk("l4_memvld", 32'(mvld4), 32'h1);
    chk("l4_memsel", 32'(msel4), 32'b0010);
    @(negedge Clk);
    ReqValid4 = 2'b10;
    ReqAddr[1] = 32'h0000_7004; ReqWr[1] = 1'b0;
    #1;
    chk("l4_rdwait_ready1", 32'(rdy4), 32'h0);
    @(negedge Clk); #1;
    chk("l4_rdwait_ready2", 32'(rdy4), 32'h0);
    #1;
    RstN = 1'b0;
    #1;
    chk("l4_rst_ready",  32'(rdy4),     32'h0);
    chk("l4_rst_memvld", 32'(mvld4),    32'h0);
    chk("l4_rst_memsel", 32'(msel4),    32'h0);
    chk("l4_rst_rspvld", 32'(rsp_vld4), 32'h0);
    chk("l4_rst_rsperr", 32'(rsp_err4), 32'h0);
    @(negedge Clk);
    RstN = 1'b1;
    ReqValid4 = 2'b00;
    for (int k = 0; k < 8; k++) begin
      @(negedge Clk); #1;
      chk($sformatf("l4_abort%0d_rspvld", k), 32'(rsp_vld4), 32'h0);
    end

    // Normal read after the abort: response exactly 5 cycles after grant.
    @(negedge Clk);
    ReqValid4 = 2'b10;
    MemRdData = 32'h0000_003F;
    #1;
    chk("l4_post_grant",  32'(rdy4),  32'h2);
    chk("l4_post_memsel", 32'(msel4), 32'b0100);
    for (int k = 1; k <= 5; k++) begin
      @(negedge Clk);
      ReqValid4 = 2'b00;
      #1;
      chk($sformatf("l4_post_c%0d_rspvld", k), 32'(rsp_vld4), (k == 5) ? 32'h2 : 32'h0);
      if (k == 5) chk("l4_post_rspdata", rsp_data4, 32'h0000_003F);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mini_core_mem_arb.md
MINI_CORE_MEM_ARB -- requirements
Module: mini_core_mem_arb

Interface
REQ-001 SHALL have parameter RD_LATENCY, default 1, memory read-data latency in cycles (legal 1..4).
REQ-002 SHALL have port Clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port RstN  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port ReqValid  input  2  per-requester request valid (bit 0 = core data port, bit 1 = loader/debug port).
REQ-005 SHALL have port ReqReady  output  2  per-requester accept; a request transfers when ReqValid[i] & ReqReady[i].
REQ-006 SHALL have port ReqAddr  input  2x32  byte address per requester.
REQ-007 SHALL have port ReqWr  input  2  1 = write, 0 = read.
REQ-008 SHALL have port ReqByteEn  input  2x4  write byte enables.
REQ-009 SHALL have port ReqWrData  input  2x32  write data.
REQ-010 SHALL have port RspValid  output  2  one-cycle read-response / error pulse for requester i.
REQ-011 SHALL have port RspData  output  32  read data, valid only with RspValid.
REQ-012 SHALL have port RspErr  output  2  qualifies RspValid[i]: access was outside all regions.
REQ-013 SHALL have port MemReqValid  output  1  fabric request strobe.
REQ-014 SHALL have ports MemAddr (32), MemWr (1), MemByteEn (4), MemWrData (32)  outputs  forwarded request fields.
REQ-015 SHALL have port MemSel  output  4  one-hot region select: [0] I_MEM, [1] D_MEM, [2] CR_MEM, [3] VGA_MEM.
REQ-016 SHALL have port MemRdData  input  32  read data, valid RD_LATENCY cycles after the read strobe.

Function
REQ-017 SHALL implement states IDLE, RD_WAIT, ERR_RSP; at most one transaction outstanding.
REQ-018 In IDLE, any ReqValid SHALL produce a grant the same cycle: ReqReady[g]=1 for exactly one g, combinational.
REQ-019 Region decode SHALL use package bounds: I 0x0-0x3FFF, D 0x4000-0x6FFF, CR 0x7000-0x7FFF, VGA 0x8000-0x115FF; floor/roof inclusive.
REQ-020 Legal grant SHALL drive MemReqValid=1, MemSel per decode, Mem* fields from requester g, same cycle.
REQ-021 Legal write: complete in grant cycle, no response, stay IDLE; back-to-back writes accepted every cycle.
REQ-022 Legal read: go RD_WAIT, count RD_LATENCY cycles, then sample MemRdData into RspData, pulse RspValid[g] one cycle, return IDLE.
REQ-023 Read turnaround SHALL be RD_LATENCY+1 cycles from grant to RspValid; ReqReady=0 throughout RD_WAIT.
REQ-024 Address above 0x115FF: ReqReady[g]=1, MemReqValid=0, MemSel=0, go ERR_RSP; next cycle pulse RspValid[g] and RspErr[g], RspData=0, return IDLE (reads and writes alike).
REQ-025 RspValid/RspErr/RspData SHALL be registered; MemSel SHALL be zero whenever MemReqValid=0.
REQ-026 A requester holding ReqValid without grant SHALL keep its request; arbiter never drops or reorders it.
REQ-027 Requests arriving in RD_WAIT/ERR_RSP SHALL wait; arbitration occurs only in IDLE, first eligible cycle being the RspValid cycle +1... SHALL instead be the same cycle state returns to IDLE.

Reset
REQ-028 RstN low SHALL immediately force IDLE, latency counter 0, RR pointer to "last = 1", all outputs 0.
REQ-029 Reset mid-RD_WAIT SHALL abort the transaction; no RspValid after RstN deasserts.

Configuration
REQ-030 With MINI_CORE_MEM_ARB_RR_EN defined, simultaneous requests SHALL alternate via round-robin pointer updated on each grant; requester 0 wins first contention after reset.
REQ-031 Without MINI_CORE_MEM_ARB_RR_EN, requester 0 SHALL always win contention (fixed priority); no pointer state exists.

Structure
REQ-032 Package mini_core_pkg SHALL hold t_arb_state enum, t_mem_sel one-hot enum, and reuse existing region FLOOR/ROOF parameters; no literals in RTL.
REQ-033 Sub-module mini_core_rr_arb SHALL implement the 2-way grant (RR or fixed per macro); FSM, decode, counter stay in top.

Verification
REQ-034 Req0 write 0x4000, BE 0xF, data 0xDEADBEEF -> same cycle MemReqValid=1, MemSel=0010, MemWrData=0xDEADBEEF; no RspValid.
REQ-035 Req1 read 0x7004 (CR_SEG7_1), RD_LATENCY=1, MemRdData=0x3F -> MemSel=0100; RspValid[1]=1, RspData=0x3F exactly 2 cycles after grant.
REQ-036 Both valid continuous reads, RR_EN -> grants 0,1,0,1; without RR_EN -> req0 only while held.
REQ-037 Req0 read 0x11600 -> MemReqValid=0; next cycle RspValid[0]=RspErr[0]=1, RspData=0.
REQ-038 Boundaries 0x3FFF/0x4000, 0x6FFF/0x7000, 0x7FFF/0x8000, 0x115FF -> MemSel 0001/0010, 0010/0100, 0100/1000, 1000.
REQ-039 RstN low during RD_WAIT (RD_LATENCY=4) -> outputs 0 immediately, no RspValid after release; next request granted normally.
